fp_rsh_sticky_pipe: RTL and testbench
=====================================

FP_RSH_STICKY_PIPE -- requirements
Module: fp_rsh_sticky_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width in bits (legal 8..64).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH)+1, meaning shift-amount width.
REQ-003 SHALL have parameter TAG_W, default 4, meaning width of opaque sideband tag.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-005 SHALL have ports: flush_i  in  1  sync pipeline clear; in_valid_i  in  1; in_ready_o  out  1.
REQ-006 SHALL have ports: data_i  in  WIDTH  operand; rsh_num_i  in  SHAMT_W  right-shift count; tag_i  in  TAG_W.
REQ-007 SHALL have ports: out_valid_o  out  1; out_ready_i  in  1; data_o  out  WIDTH  shifted operand.
REQ-008 SHALL have ports: guard_o  out  1  last bit shifted out; sticky_o  out  1  OR of all bits below guard; sat_o  out  1  rsh_num_i >= WIDTH; tag_o  out  TAG_W.
REQ-009 One clock, clk; reset rst is asynchronous and active-high.

Function
REQ-010 SHALL compute data_o = data_i >> rsh_num_i (logical, zero-fill); data_o = 0 when rsh_num_i >= WIDTH.
REQ-011 SHALL set guard_o = data_i[rsh_num_i-1] for 1 <= rsh_num_i <= WIDTH, else 0.
REQ-012 SHALL set sticky_o = OR(data_i[rsh_num_i-2:0]) for 2 <= rsh_num_i <= WIDTH+1; OR(data_i) excluding guard bit position when rsh_num_i = WIDTH; OR(data_i) when rsh_num_i > WIDTH; 0 when rsh_num_i < 2.
REQ-013 SHALL derive sticky via lost-bits mask: mask[k] = (k+2 <= rsh_num_i) for k in 0..WIDTH-3 plus top-bit handling, sticky = |(data_i & mask); no priority/loop encoding.
REQ-014 SHALL be a 2-stage pipeline: S1 registers data_i, saturated rsh, tag, guard, sticky; S2 registers shifted data, guard, sticky, sat, tag; latency exactly 2 cycles with no stalls.
REQ-015 SHALL accept input when in_valid_i && in_ready_o; produce output transfer when out_valid_o && out_ready_i.
REQ-016 SHALL drive in_ready_o = !s1_valid || (!s2_valid || out_ready_i) (S2 free or draining); combinational, no dependency on in_valid_i.
REQ-017 SHALL hold data_o, guard_o, sticky_o, sat_o, tag_o stable while out_valid_o && !out_ready_i.
REQ-018 SHALL sustain 1 transfer/cycle when out_ready_i held high; no bubbles inserted.
REQ-019 SHALL advance S1->S2 when S2 empty or draining in same cycle; simultaneous accept-and-drain SHALL not lose or duplicate an entry.
REQ-020 SHALL on flush_i clear both stage valids next edge; input offered in flush cycle SHALL be dropped; flush has priority over accept.
REQ-021 SHALL treat rsh_num_i = 0 as passthrough: data_o = data_i, guard_o = sticky_o = sat_o = 0.

Reset
REQ-022 SHALL on rst asserted clear s1_valid, s2_valid, out_valid_o to 0 immediately (async).
REQ-023 SHALL reset data_o, guard_o, sticky_o, sat_o, tag_o to 0.
REQ-024 SHALL drive in_ready_o = 1 in first cycle after rst deassertion; reset mid-transfer SHALL discard in-flight entries.

Structure
REQ-025 SHALL place rsh result struct (data, guard, sticky, sat, tag) typedef and SHAMT_W helper function in shared package fp_rsh_pkg.
REQ-026 SHALL instantiate one sub-module fp_rsh_lost_bits_mask (params WIDTH, SHAMT_W; in rsh_num; out mask) in S1.
REQ-027 SHALL contain no latches; all stage registers on clk posedge / rst posedge.

Verification (WIDTH=32)
REQ-028 data_i=0x8000_0001, rsh=1, out_ready=1 -> after 2 cycles data_o=0x4000_0000, guard=1, sticky=0, sat=0.
REQ-029 data_i=0x0000_0007, rsh=3 -> data_o=0, guard=1, sticky=1; rsh=2 -> data_o=1, guard=1, sticky=1.
REQ-030 data_i=0xFFFF_FFFF, rsh=32 -> data_o=0, guard=1, sticky=1, sat=1; rsh=40 -> guard=0, sticky=1, sat=1.
REQ-031 back-to-back 8 inputs, out_ready low cycles 3-5 -> in_ready drops after 2 held entries, all 8 outputs in order, tags 0..7, no duplicates.
REQ-032 flush_i in cycle with 2 entries in flight and in_valid=1 -> out_valid=0 next cycle, no entry emerges; rst asserted mid-stream -> out_valid=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/fp_rsh_pkg.sv
// Shared types and helpers for the sticky right-shift pipeline.
//   rsh_res_t   : one output-stage result (shifted data, guard, sticky,
//                 saturation flag, sideband tag). Fields are sized for the
//                 widest legal configuration (WIDTH <= 64, TAG_W <= 16);
//                 narrower instances use the low bits only.
//   shamt_width : shift-amount width needed to express 0..2*WIDTH-1.
package fp_rsh_pkg;

  localparam int RES_DATA_MAX_W = 64;
  localparam int RES_TAG_MAX_W  = 16;

  typedef struct packed {
    logic [RES_DATA_MAX_W-1:0] data;
    logic                      guard;
    logic                      sticky;
    logic                      sat;
    logic [RES_TAG_MAX_W-1:0]  tag;
  } rsh_res_t;

  function automatic int shamt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/fp_rsh_lost_bits_mask.sv
// Lost-bits mask for the sticky bit.
//   rsh_num : requested right-shift count
//   mask    : bit k set when data bit k lies strictly below the guard
//             position, i.e. k + 2 <= rsh_num.
// The same compare covers the top bit: it joins the mask only once the
// shift exceeds WIDTH, because at rsh_num == WIDTH it is the guard bit.
module fp_rsh_lost_bits_mask #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = fp_rsh_pkg::shamt_width(WIDTH)
) (
  input  logic [SHAMT_W-1:0] rsh_num,
  output logic [WIDTH-1:0]   mask
);

  for (genvar k = 0; k < WIDTH; k++) begin : g_mask
    assign mask[k] = (int'(rsh_num) >= k + 2);
  end

endmodule

// File: rtl/fp_rsh_sticky_pipe.sv
// Two-stage logical right shifter with guard/sticky extraction.
//   clk, rst                  : clock, async active-high reset
//   flush_i                   : synchronous clear of both stages (wins over accept)
//   in_valid_i / in_ready_o   : input handshake
//   data_i, rsh_num_i, tag_i  : operand, shift count, opaque sideband tag
//   out_valid_o / out_ready_i : output handshake
//   data_o                    : data_i >> rsh_num_i (zero when rsh_num_i >= WIDTH)
//   guard_o                   : last bit shifted out
//   sticky_o                  : OR of all bits below the guard position
//   sat_o                     : rsh_num_i >= WIDTH
//   tag_o                     : tag carried alongside the result
// S1 captures the operand, a shift count clamped to WIDTH, guard and sticky;
// S2 performs the barrel shift and holds the result until it is taken.
module fp_rsh_sticky_pipe
  import fp_rsh_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = shamt_width(WIDTH),
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] rsh_num_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               guard_o,
  output logic               sticky_o,
  output logic               sat_o,
  output logic [TAG_W-1:0]   tag_o
);

  localparam logic [SHAMT_W-1:0] SHAMT_FULL = SHAMT_W'(WIDTH);

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_data_q, s1_data_d;
  logic [SHAMT_W-1:0] s1_rsh_q, s1_rsh_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic               s1_guard_q, s1_guard_d;
  logic               s1_sticky_q, s1_sticky_d;

  logic               s2_valid_q, s2_valid_d;
  rsh_res_t           s2_res_q, s2_res_d;

  logic               s2_free;
  logic               accept;
  logic               s1_move;
  logic [WIDTH-1:0]   lost_mask;
  logic [WIDTH-1:0]   guard_vec;
  logic [SHAMT_W-1:0] rsh_m1;
  logic               guard_in_range;

  fp_rsh_lost_bits_mask #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_lost_bits_mask (
    .rsh_num (rsh_num_i),
    .mask    (lost_mask)
  );

  always_comb begin
    s2_free    = !s2_valid_q || out_ready_i;
    in_ready_o = !s1_valid_q || s2_free;
    accept     = in_valid_i && in_ready_o && !flush_i;
    s1_move    = s1_valid_q && s2_free && !flush_i;

    // Guard is bit rsh-1; shifting by rsh-1 and taking bit 0 avoids a
    // variable bit-select whose index would be wider than the vector.
    rsh_m1         = rsh_num_i - SHAMT_W'(1);
    guard_vec      = data_i >> rsh_m1;
    guard_in_range = (rsh_num_i != '0) && (rsh_num_i <= SHAMT_FULL);

    s1_data_d   = s1_data_q;
    s1_rsh_d    = s1_rsh_q;
    s1_tag_d    = s1_tag_q;
    s1_guard_d  = s1_guard_q;
    s1_sticky_d = s1_sticky_q;
    if (accept) begin
      s1_data_d   = data_i;
      s1_rsh_d    = (rsh_num_i >= SHAMT_FULL) ? SHAMT_FULL : rsh_num_i;
      s1_tag_d    = tag_i;
      s1_guard_d  = guard_in_range & guard_vec[0];
      s1_sticky_d = |(data_i & lost_mask);
    end

    s1_valid_d = flush_i ? 1'b0 : (accept || (s1_valid_q && !s1_move));
    s2_valid_d = flush_i ? 1'b0 : (s1_move || (s2_valid_q && !out_ready_i));

    s2_res_d = s2_res_q;
    if (s1_move) begin
      // A clamped count of WIDTH shifts everything out, giving zero.
      s2_res_d.data   = RES_DATA_MAX_W'(s1_data_q >> s1_rsh_q);
      s2_res_d.guard  = s1_guard_q;
      s2_res_d.sticky = s1_sticky_q;
      s2_res_d.sat    = (s1_rsh_q == SHAMT_FULL);
      s2_res_d.tag    = RES_TAG_MAX_W'(s1_tag_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_rsh_q    <= '0;
      s1_tag_q    <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_res_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_rsh_q    <= s1_rsh_d;
      s1_tag_q    <= s1_tag_d;
      s1_guard_q  <= s1_guard_d;
      s1_sticky_q <= s1_sticky_d;
      s2_valid_q  <= s2_valid_d;
      s2_res_q    <= s2_res_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign data_o      = s2_res_q.data[WIDTH-1:0];
  assign guard_o     = s2_res_q.guard;
  assign sticky_o    = s2_res_q.sticky;
  assign sat_o       = s2_res_q.sat;
  assign tag_o       = s2_res_q.tag[TAG_W-1:0];

endmodule

// File: tb/tb_fp_rsh_sticky_pipe.sv
module tb_fp_rsh_sticky_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic        guard;
    logic        sticky;
    logic        sat;
    logic [3:0]  tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] data_i;
  logic [5:0]  rsh_num_i;
  logic [3:0]  tag_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] data_o;
  logic        guard_o;
  logic        sticky_o;
  logic        sat_o;
  logic [3:0]  tag_o;

  int   n_cmp;
  int   n_err;
  exp_t sb_q[$];
  logic cur_override;
  exp_t cur_exp;
  int   ready_mode;
  logic hold_pend;
  logic [38:0] hold_val;

  fp_rsh_sticky_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      (data_i),
    .rsh_num_i   (rsh_num_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .guard_o     (guard_o),
    .sticky_o    (sticky_o),
    .sat_o       (sat_o),
    .tag_o       (tag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shift by n, guard is bit n-1, sticky is "anything nonzero
  // below bit n-1", computed with plain 64-bit arithmetic.
  function automatic exp_t model(input logic [31:0] d, input int n, input logic [3:0] t);
    exp_t r;
    logic [63:0] d64;
    logic [63:0] sh;
    d64 = {32'd0, d};
    r.data = (n >= 32) ? 32'd0 : d64[31:0] >> n;
    if (n >= 1 && n <= 32) begin
      sh = d64 >> (n - 1);
      r.guard = sh[0];
    end else begin
      r.guard = 1'b0;
    end
    if (n < 2)
      r.sticky = 1'b0;
    else if (n - 1 >= 32)
      r.sticky = (d != 32'd0);
    else
      r.sticky = ((d64 % (64'd1 << (n - 1))) != 64'd0);
    r.sat = (n >= 32);
    r.tag = t;
    return r;
  endfunction

  function automatic exp_t mk(input logic [31:0] d, input logic g, input logic s,
                              input logic sat, input logic [3:0] t);
    exp_t r;
    r.data = d; r.guard = g; r.sticky = s; r.sat = sat; r.tag = t;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // out_ready driver: 0 = high, 1 = random, 2 = low in cycles 3..5, 3 = low
  initial begin : ready_drv
    int cyc;
    int last_mode;
    cyc = 0;
    last_mode = 0;
    out_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_mode != last_mode) begin
        cyc = 0;
        last_mode = ready_mode;
      end else begin
        cyc++;
      end
      case (ready_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = ($urandom_range(0, 3) != 0);
        2:       out_ready_i = !(cyc >= 3 && cyc <= 5);
        default: out_ready_i = 1'b0;
      endcase
    end
  end

  // Scoreboard: push on accepted input, pop and compare on output transfer.
  always @(posedge clk) begin : scoreboard
    exp_t e;
    int   occ;
    if (rst) begin
      sb_q.delete();
      hold_pend = 1'b0;
    end else begin
      occ = sb_q.size();
      chk("in_ready_vs_occupancy", 64'(in_ready_o), 64'((occ < 2) || out_ready_i));
      if (hold_pend) begin
        chk("hold_valid", 64'(out_valid_o), 64'd1);
        chk("hold_payload", 64'({data_o, guard_o, sticky_o, sat_o, tag_o}), 64'(hold_val));
      end
      if (out_valid_o && out_ready_i) begin
        if (occ == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got data 0x%0h tag %0d, expected no output", data_o, tag_o);
        end else begin
          e = sb_q.pop_front();
          chk("data", 64'(data_o), 64'(e.data));
          chk("guard", 64'(guard_o), 64'(e.guard));
          chk("sticky", 64'(sticky_o), 64'(e.sticky));
          chk("sat", 64'(sat_o), 64'(e.sat));
          chk("tag", 64'(tag_o), 64'(e.tag));
        end
      end
      hold_pend = out_valid_o && !out_ready_i && !flush_i;
      hold_val  = {data_o, guard_o, sticky_o, sat_o, tag_o};
      if (flush_i)
        sb_q.delete();
      else if (in_valid_i && in_ready_o)
        sb_q.push_back(cur_override ? cur_exp : model(data_i, int'(rsh_num_i), tag_i));
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [5:0] n, input logic [3:0] t,
                      input logic ovr, input exp_t e, output int waited);
    waited = 0;
    data_i = d; rsh_num_i = n; tag_i = t;
    cur_override = ovr; cur_exp = e;
    in_valid_i = 1'b1;
    forever begin
      @(posedge clk);
      if (in_ready_o) break;
      waited++;
      if (waited > 100) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
        break;
      end
    end
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic set_mode(input int m);
    ready_mode = m;
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_silence(input string nm, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      chk(nm, 64'(out_valid_o), 64'd0);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    int w;
    int stalls;
    logic [31:0] d;
    logic [5:0]  n;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0;
    data_i = '0; rsh_num_i = '0; tag_i = '0;
    cur_override = 1'b0; cur_exp = '0; ready_mode = 0;
    hold_pend = 1'b0; hold_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid_o), 64'd0);
    chk("reset_in_ready", 64'(in_ready_o), 64'd1);
    chk("reset_payload", 64'({data_o, guard_o, sticky_o, sat_o, tag_o}), 64'd0);
    @(negedge clk);

    // Latency: output presented exactly two edges after the accept edge.
    send(32'h8000_0001, 6'd1, 4'd0, 1'b1, mk(32'h4000_0000, 1'b1, 1'b0, 1'b0, 4'd0), w);
    chk("latency_not_after_one", 64'(out_valid_o), 64'd0);
    @(negedge clk);
    chk("latency_two", 64'(out_valid_o), 64'd1);
    chk("latency_data", 64'(data_o), 64'h4000_0000);
    @(negedge clk);

    // Directed boundary vectors.
    send(32'h0000_0007, 6'd3,  4'd1, 1'b1, mk(32'h0000_0000, 1'b1, 1'b1, 1'b0, 4'd1), w);
    send(32'h0000_0007, 6'd2,  4'd2, 1'b1, mk(32'h0000_0001, 1'b1, 1'b1, 1'b0, 4'd2), w);
    send(32'hFFFF_FFFF, 6'd32, 4'd3, 1'b1, mk(32'h0000_0000, 1'b1, 1'b1, 1'b1, 4'd3), w);
    send(32'hFFFF_FFFF, 6'd40, 4'd4, 1'b1, mk(32'h0000_0000, 1'b0, 1'b1, 1'b1, 4'd4), w);
    send(32'h1234_5678, 6'd0,  4'd5, 1'b1, mk(32'h1234_5678, 1'b0, 1'b0, 1'b0, 4'd5), w);
    send(32'h8000_0000, 6'd32, 4'd6, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1, 4'd6), w);
    send(32'h8000_0000, 6'd33, 4'd7, 1'b1, mk(32'h0000_0000, 1'b0, 1'b1, 1'b1, 4'd7), w);
    send(32'h4000_0000, 6'd31, 4'd8, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'd8), w);
    send(32'h0000_0001, 6'd1,  4'd9, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'd9), w);
    send(32'h0000_0003, 6'd63, 4'hA, 1'b1, mk(32'h0000_0000, 1'b0, 1'b1, 1'b1, 4'hA), w);
    repeat (4) @(negedge clk);

    // Burst of 8 with a 3-cycle output stall.
    set_mode(2);
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      send($urandom, 6'($urandom_range(0, 40)), 4'(i), 1'b0, '0, w);
      stalls += w;
    end
    chk("burst_in_ready_dropped", 64'(stalls > 0), 64'd1);
    set_mode(0);
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    chk("burst_drained", 64'(sb_q.size()), 64'd0);

    // Flush with two entries in flight and a new input offered.
    set_mode(3);
    send(32'hAAAA_5555, 6'd4, 4'd1, 1'b0, '0, w);
    send(32'h5555_AAAA, 6'd5, 4'd2, 1'b0, '0, w);
    chk("pre_flush_out_valid", 64'(out_valid_o), 64'd1);
    chk("pre_flush_in_ready", 64'(in_ready_o), 64'd0);
    data_i = 32'hDEAD_BEEF; rsh_num_i = 6'd1; tag_i = 4'd3; in_valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush_out_valid", 64'(out_valid_o), 64'd0);
    chk("flush_in_ready", 64'(in_ready_o), 64'd1);
    ready_mode = 0;
    expect_silence("flush_nothing_emerges", 5);

    // Asynchronous reset mid-stream.
    set_mode(3);
    send(32'h0F0F_0F0F, 6'd7, 4'd4, 1'b0, '0, w);
    send(32'hF0F0_F0F0, 6'd9, 4'd5, 1'b0, '0, w);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_async_payload", 64'({data_o, guard_o, sticky_o, sat_o, tag_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready_o), 64'd1);
    ready_mode = 0;
    expect_silence("rst_nothing_emerges", 5);

    // Randomised traffic with random backpressure and occasional flushes.
    set_mode(1);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       n = 6'($urandom_range(0, 3));
        1:       n = 6'($urandom_range(30, 34));
        default: n = 6'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 5))
        0:       d = 32'hFFFF_FFFF;
        1:       d = 32'd1 << $urandom_range(0, 31);
        default: d = $urandom;
      endcase
      send(d, n, 4'(i), 1'b0, '0, w);
      if ((i % 97) == 50) begin
        data_i = $urandom; in_valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; in_valid_i = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    set_mode(0);
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge clk);
    chk("final_drained", 64'(sb_q.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
